// File: rtl/uartrx_fifo.sv
// ============================================================================
// Module   : uartrx_fifo
// Purpose  : UART receiver with a configurable frame width that feeds an FWFT FIFO.
//            Optional even parity is enabled with the UARTRX_FIFO_PARITY_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uartrx_fifo #(
    parameter int ClockFrequencyHz    = 20_250_000,
    parameter int BaudRate            = 20_250_000 / 2,
    parameter int DataBits            = 8,
    parameter int FifoAddressBitWidth = 3,
    parameter int SyncStages          = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    input  logic                         rd_en,
    output logic [DataBits-1:0]          rd_data,
    output logic                         rd_valid,
    output logic [FifoAddressBitWidth:0] count,
    output logic                         overrun,
    input  logic                         clr_overrun,
`ifdef UARTRX_FIFO_PARITY_EN
    output logic                         parity_error,
`endif
    output logic                         frame_error
);

    localparam int c_bit_cycles = ClockFrequencyHz / BaudRate;
    localparam int c_cnt_w      = (c_bit_cycles > 2) ? $clog2(c_bit_cycles) : 1;
    localparam int c_idx_w      = $clog2(DataBits);
    localparam int c_aw         = FifoAddressBitWidth;
    localparam int c_depth      = 1 << FifoAddressBitWidth;
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_bit_cycles / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_bit_cycles - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DataBits - 1);

    if (c_bit_cycles < 2) begin : g_bitcycles_check
        $error("uartrx_fifo: ClockFrequencyHz/BaudRate must be >= 2");
    end
    if (SyncStages < 2) begin : g_sync_check
        $error("uartrx_fifo: SyncStages must be >= 2");
    end

`ifdef UARTRX_FIFO_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_STOP = 3'd3, S_BREAK = 3'd4, S_PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_STOP = 3'd3, S_BREAK = 3'd4
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SyncStages-1:0]   r_sync;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [DataBits-1:0]     r_shift;
    logic [DataBits-1:0]     r_mem [c_depth];
    logic [c_aw:0]           r_wptr;
    logic [c_aw:0]           r_rptr;
    logic [c_aw:0]           w_wptr_nxt;
    logic [c_aw:0]           w_rptr_nxt;
    logic                    w_rxs;
    logic                    w_tick;
    logic                    w_stop_tick;
    logic                    w_par_ok;
    logic                    w_word_ok;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SyncStages-2:0], rx};
    end

    assign w_rxs  = r_sync[SyncStages-1];
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_rxs) w_state_nxt = S_START;
            S_START:  if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
`ifdef UARTRX_FIFO_PARITY_EN
            S_DATA:   if (w_tick && r_idx == c_idx_last) w_state_nxt = S_PARITY;
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`else
            S_DATA:   if (w_tick && r_idx == c_idx_last) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_tick) w_state_nxt = w_rxs ? S_IDLE : S_BREAK;
            S_BREAK:  if (w_rxs) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Counter reloads to half a bit on the falling edge so samples land mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE)  r_cnt <= c_cnt_half;
            else if (w_tick)        r_cnt <= c_cnt_full;
            else                    r_cnt <= r_cnt - 1'b1;
            if (r_state == S_START) r_idx <= '0;
            if (r_state == S_DATA && w_tick) begin
                r_shift[r_idx] <= w_rxs;
                r_idx          <= r_idx + 1'b1;
            end
        end
    end

`ifdef UARTRX_FIFO_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             r_par <= 1'b0;
        else if (r_state == S_PARITY && w_tick) r_par <= w_rxs;
    end
    assign w_par_ok = ~(^{r_shift, r_par});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_error <= 1'b0;
        else     parity_error <= w_stop_tick && !w_par_ok;
    end
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_stop_tick = (r_state == S_STOP) && w_tick;
    assign w_word_ok   = w_stop_tick && w_rxs && w_par_ok;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                        (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_pop      = rd_en && !w_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still succeeds.
    assign w_push     = w_word_ok && (!w_full || w_pop);
    assign w_ovf      = w_word_ok && w_full && !w_pop;
    assign w_wptr_nxt = r_wptr + (c_aw+1)'(w_push);
    assign w_rptr_nxt = r_rptr + (c_aw+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_aw-1:0]] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            rd_data     <= '1;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            frame_error <= w_stop_tick && !w_rxs;
            if (w_ovf)            overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
            if (w_wptr_nxt == w_rptr_nxt)               rd_data <= '1;
            else if (w_push && (w_rptr_nxt == r_wptr))  rd_data <= r_shift;
            else                                        rd_data <= r_mem[w_rptr_nxt[c_aw-1:0]];
        end
    end

    assign rd_valid = !w_empty;
    assign count    = r_wptr - r_rptr;

endmodule

`default_nettype wire

// File: tb/tb_uartrx_fifo.sv
// ============================================================================
// Module   : tb_uartrx_fifo
// Purpose  : Directed self-checking bench for uartrx_fifo (10 clocks per bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uartrx_fifo;

`ifdef UARTRX_FIFO_PARITY_EN
    localparam int DB = 7;
    localparam bit PAR = 1'b1;
`else
    localparam int DB = 8;
    localparam bit PAR = 1'b0;
`endif
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          rd_en = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [DB-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_error;
    logic          parity_error;

    int n_checks = 0;
    int n_pass   = 0;
    int fe_pulses = 0;
    int pe_pulses = 0;

    uartrx_fifo #(
        .ClockFrequencyHz    (1_000_000),
        .BaudRate            (100_000),
        .DataBits            (DB),
        .FifoAddressBitWidth (AW),
        .SyncStages          (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
`ifdef UARTRX_FIFO_PARITY_EN
        .parity_error (parity_error),
`endif
        .frame_error  (frame_error)
    );

`ifndef UARTRX_FIFO_PARITY_EN
    assign parity_error = 1'b0;
`endif

    always #500 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error)  fe_pulses++;
        if (parity_error) pe_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; each bit is held for 10 clocks.
    task automatic send_frame(input logic [15:0] d, input bit par_flip, input int stop_low_bits);
        logic p;
        p = 1'b0;
        rx = 1'b0;
        idle(10);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            p  = p ^ d[i];
            idle(10);
        end
        if (PAR) begin
            rx = p ^ par_flip;
            idle(10);
        end
        if (stop_low_bits > 0) begin
            rx = 1'b0;
            idle(10 * stop_low_bits);
        end
        rx = 1'b1;
        idle(10);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int fe0;
        idle(3);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_data", {{(32-DB){1'b0}}, rd_data}, (32'd1 << DB) - 1);
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        check("reset_frame_error", {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        idle(3);

`ifndef UARTRX_FIFO_PARITY_EN
        // 1: single frame, then pop to empty
        send_frame(16'hAA, 1'b0, 0);
        check("t1_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("t1_rd_data", {24'd0, rd_data}, 32'hAA);
        check("t1_count", {29'd0, count}, 32'd1);
        pop();
        check("t1_pop_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("t1_pop_rd_data", {24'd0, rd_data}, 32'hFF);
        check("t1_pop_count", {29'd0, count}, 32'd0);

        // 2: fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) send_frame(16'(i), 1'b0, 0);
        check("t2_count_full", {29'd0, count}, 32'd4);
        check("t2_overrun_pre", {31'd0, overrun}, 32'd0);
        send_frame(16'h05, 1'b0, 0);
        check("t2_overrun", {31'd0, overrun}, 32'd1);
        check("t2_count_ovf", {29'd0, count}, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_read%0d", i), {24'd0, rd_data}, 32'(i));
            pop();
        end
        check("t2_empty", {31'd0, rd_valid}, 32'd0);
        check("t2_overrun_sticky", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("t2_overrun_clr", {31'd0, overrun}, 32'd0);

        // 3: full FIFO with a pop on the push edge
        for (int i = 1; i <= 4; i++) send_frame(16'(i), 1'b0, 0);
        fork
            send_frame(16'h05, 1'b0, 0);
            begin
                idle(97);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        idle(2);
        check("t3_count", {29'd0, count}, 32'd4);
        check("t3_overrun", {31'd0, overrun}, 32'd0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("t3_read%0d", i), {24'd0, rd_data}, 32'(i));
            pop();
        end
        check("t3_empty_data", {24'd0, rd_data}, 32'hFF);
        check("t3_empty_count", {29'd0, count}, 32'd0);

        // 4: framing error with a long break
        fe0 = fe_pulses;
        send_frame(16'h55, 1'b0, 2);
        check("t4_fe_pulses", 32'(fe_pulses - fe0), 32'd1);
        check("t4_count", {29'd0, count}, 32'd0);
        send_frame(16'h3C, 1'b0, 0);
        check("t4_next_data", {24'd0, rd_data}, 32'h3C);
        check("t4_next_count", {29'd0, count}, 32'd1);
        check("t4_fe_total", 32'(fe_pulses - fe0), 32'd1);
        pop();

        // 5: glitch rejection, then reset mid-frame
        fe0 = fe_pulses;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check("t5_glitch_count", {29'd0, count}, 32'd0);
        check("t5_glitch_fe", 32'(fe_pulses - fe0), 32'd0);
        rx = 1'b0;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            idle(10);
        end
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("t5_rst_count", {29'd0, count}, 32'd0);
        check("t5_rst_data", {24'd0, rd_data}, 32'hFF);
        rst = 1'b0;
        idle(5);
        send_frame(16'h81, 1'b0, 0);
        check("t5_rx_data", {24'd0, rd_data}, 32'h81);
        check("t5_rx_count", {29'd0, count}, 32'd1);
        check("t5_fe", 32'(fe_pulses - fe0), 32'd0);
`else
        // 6: even parity accept and reject
        send_frame(16'h41, 1'b0, 0);
        check("t6_good_count", {29'd0, count}, 32'd1);
        check("t6_good_data", {25'd0, rd_data}, 32'h41);
        check("t6_good_pe", 32'(pe_pulses), 32'd0);
        pop();
        send_frame(16'h41, 1'b1, 0);
        check("t6_bad_pe", 32'(pe_pulses), 32'd1);
        check("t6_bad_count", {29'd0, count}, 32'd0);
        check("t6_bad_overrun", {31'd0, overrun}, 32'd0);
        check("t6_bad_fe", 32'(fe_pulses), 32'd0);
        send_frame(16'h2A, 1'b0, 0);
        check("t6_after_data", {25'd0, rd_data}, 32'h2A);
        check("t6_after_count", {29'd0, count}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uartrx_fifo.md
Name: uartrx_fifo

Overview:
Parametrised successor to the single-byte UART receiver used behind the RAM/IO bridge. It deserialises frames with a configurable data width and buffers the received words in an internal FWFT (first-word-fall-through) FIFO, so the bridge can drain bursts of input without losing data. Overflow and framing faults are reported instead of silently dropped. An empty read returns all ones, matching the bridge's "-1 means no data" convention.

Parameters:
ClockFrequencyHz, 20_250_000, system clock frequency.
BaudRate, 20_250_000/2, line rate. BitCycles = ClockFrequencyHz/BaudRate, integer division, must be >= 2 (elaboration $error otherwise).
DataBits, 8, data bits per frame (5..16), sent LSB first.
FifoAddressBitWidth, 3, FIFO depth = 2^FifoAddressBitWidth entries.
SyncStages, 2, input synchroniser flip-flops on rx (>= 2).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rx  in  1  serial input, idle high
rd_en  in  1  pop head entry when rd_valid=1
rd_data  out  DataBits  head entry; all ones when empty
rd_valid  out  1  FIFO not empty
count  out  FifoAddressBitWidth+1  number of stored entries
overrun  out  1  sticky: a complete frame arrived while FIFO was full
clr_overrun  in  1  clears overrun
frame_error  out  1  one-cycle pulse when the stop bit samples 0

Behaviour:
- Reset (async, rst=1) forces: FIFO empty, count=0, rd_valid=0, rd_data=all ones, overrun=0, frame_error=0, FSM=IDLE, synchroniser chain all 1s. Reset mid-frame discards the partial frame.
- rx passes through SyncStages flops; the FSM sees only the synchronised value rxs.
- FSM:
  - IDLE: on rxs=0, load the bit counter with BitCycles/2 - 1 -> START.
  - START: at counter 0, sample rxs. If 0, -> DATA with bit index 0 and counter BitCycles-1. If 1, it was a glitch -> IDLE, nothing reported.
  - DATA: at each counter 0, shift rxs into bit [index] and reload the counter. After bit DataBits-1 -> STOP (-> PARITY when the feature is enabled).
  - STOP: at counter 0, sample rxs.
    - If 1 and FIFO not full: push the word -> IDLE.
    - If 1 and FIFO full: drop the word, set overrun -> IDLE.
    - If 0: pulse frame_error for 1 cycle, drop the word -> BREAK.
  - BREAK: wait for rxs=1 -> IDLE.
- FIFO: circular buffer with FifoAddressBitWidth+1-bit read/write pointers; full/empty are decided by comparing the pointer MSBs. Pointers wrap modulo 2^(FifoAddressBitWidth+1).
- Push lands on the clock edge of the stop-bit sample. The word appears on rd_data and rd_valid rises on the next cycle.
- rd_data is registered FWFT. After a pop, the next entry (or all ones if now empty) is visible one cycle later.
- rd_en while empty: ignored, no pointer change.
- Push and pop on the same cycle: both succeed and count is unchanged. This holds even when full, because the pop frees the slot that the push uses.
- overrun: set has priority over a simultaneous clr_overrun. It stays set until cleared; reception continues normally.
- count always equals write pointer minus read pointer.

Optional Feature:
UARTRX_FIFO_PARITY_EN
- Defined:
  - The frame carries one even-parity bit between the data bits and the stop bit. The FSM gains a PARITY state sampled at counter 0.
  - Adds output port parity_error (1 bit, reset 0), a one-cycle pulse issued on the stop-bit cycle when the parity mismatches.
  - A word with bad parity is not pushed and does not affect overrun.
- Undefined: no parity bit, no PARITY state, no parity_error port.

Test Plan:
All scenarios use ClockFrequencyHz=1_000_000, BaudRate=100_000 (10 cycles/bit), DataBits=8, FifoAddressBitWidth=2, unless stated otherwise.
1. Reset, then drive frame 0xAA -> rd_valid=1, rd_data=8'hAA, count=1. Pulse rd_en -> rd_valid=0, rd_data=8'hFF, count=0.
2. Send 0x01,0x02,0x03,0x04 back-to-back -> count=4. Send 0x05 -> overrun=1, count=4. Pop four times -> 01,02,03,04 in order. Pulse clr_overrun -> overrun=0.
3. FIFO full and rd_en asserted on the stop-bit push cycle -> count stays 4; the next reads return 02,03,04,05.
4. Frame 0x55 with stop bit driven 0 for 2 bit times -> frame_error high exactly 1 cycle, count=0. A following frame 0x3C is received correctly after rx returns high.
5. Low glitch on rx of 3 cycles -> no push, no error, FSM back in IDLE. Assert rst mid-frame (after bit 3) -> count=0, rd_data=8'hFF; the next full frame 0x81 is received.
6. With UARTRX_FIFO_PARITY_EN, DataBits=7: 0x41 with correct even parity -> pushed. Same frame with the parity bit inverted -> parity_error pulse, count unchanged.
